// File: rtl/mig_sequencer.sv
// Majority-inverter graph evaluator: walks a small program of MAJ3 nodes,
// one node per clock, through a single shared majority evaluator.
module mig_sequencer #(
  parameter int NODES = 8,
  parameter int IDXW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [14:0] cfg_data,
  input  logic [3:0]  cfg_len,
  input  logic [6:0]  x,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        out,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [14:0]       r_prog [NODES];
  logic [NODES-1:0]  r_res;
  logic [6:0]        r_x;
  logic [3:0]        r_len;
  logic [2:0]        r_ptr;
  logic              r_out;
  logic              r_err;

  logic [14:0]       w_node;
  logic              w_a, w_b, w_c;
  logic              w_maj;
  logic              w_fault;
  logic              w_last;
  logic              w_badlen;

  // Operand value: index 0..6 selects a latched input, 7 is constant 0,
  // 8+k selects node k's stored result; bit 4 inverts.
  function automatic logic op_val(input logic [4:0] f, input logic [6:0] xv,
                                  input logic [NODES-1:0] res);
    logic [IDXW-1:0] idx;
    logic            v;
    idx = f[IDXW-1:0];
    if (idx < 4'd7)       v = xv[idx[2:0]];
    else if (idx == 4'd7) v = 1'b0;
    else                  v = res[idx[2:0]];
    return v ^ f[4];
  endfunction

  // A node may only consume results of strictly earlier nodes.
  function automatic logic is_fwd(input logic [4:0] f, input logic [2:0] ptr);
    return f[3] && (f[2:0] >= ptr);
  endfunction

  assign w_node   = r_prog[r_ptr];
  assign w_a      = op_val(w_node[14:10], r_x, r_res);
  assign w_b      = op_val(w_node[9:5],   r_x, r_res);
  assign w_c      = op_val(w_node[4:0],   r_x, r_res);
  assign w_maj    = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
  assign w_fault  = is_fwd(w_node[14:10], r_ptr) | is_fwd(w_node[9:5], r_ptr) |
                    is_fwd(w_node[4:0], r_ptr);
  assign w_last   = ({1'b0, r_ptr} == (r_len - 4'd1));
  assign w_badlen = (cfg_len == 4'd0) || (cfg_len > 4'd8);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_badlen ? S_FIN : S_EVAL;
      S_EVAL:  if (w_fault || w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) r_prog[i] <= '0;
      r_res <= '0;
      r_x   <= '0;
      r_len <= '0;
      r_ptr <= '0;
      r_out <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_we) r_prog[cfg_addr] <= cfg_data;
          if (start) begin
            r_x   <= x;
            r_len <= cfg_len;
            r_ptr <= '0;
            if (w_badlen) begin
              r_out <= 1'b0;
              r_err <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          r_res[r_ptr] <= w_maj;
          r_ptr        <= r_ptr + 3'd1;
          if (w_fault) begin
            r_out <= 1'b0;
            r_err <= 1'b1;
          end else if (w_last) begin
            r_out <= w_maj;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FIN);
  assign out  = r_out;
  assign err  = r_err;

endmodule

// File: doc/mig_sequencer.md
MIG_SEQUENCER -- requirements
Module: mig_sequencer

Interface
REQ-001 Parameter: NODES, 8, max majority nodes per program (fixed at 8 for this revision).
REQ-002 Parameter: IDXW, 4, operand index width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 cfg_we  input  1  program-memory write strobe.
REQ-006 cfg_addr  input  3  node slot written.
REQ-007 cfg_data  input  15  three operands {inv,idx[3:0]}: [14:10]=A, [9:5]=B, [4:0]=C.
REQ-008 cfg_len  input  4  node count used by next run (legal 1..8), sampled at start.
REQ-009 x  input  7  primary inputs x0..x6 (bit i = xi).
REQ-010 start  input  1  request one evaluation.
REQ-011 busy  output  1  high from accepted start until done cycle inclusive.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 out  output  1  result of final node; held until next done.
REQ-014 err  output  1  error flag, valid with done, held until next done.

Function
REQ-015 Operand index map: 0..6 = x0..x6 (latched copy), 7 = constant 0, 8+k = result of node k.
REQ-016 Operand value = source XOR inv; node result = MAJ(A,B,C) = AB|AC|BC.
REQ-017 Exactly one shared MAJ3 evaluator; one node evaluated per clock.
REQ-018 States: IDLE, EVAL, FIN.
REQ-019 IDLE: start=1 -> latch x and cfg_len, node pointer=0, go EVAL; start ignored in EVAL/FIN.
REQ-020 EVAL: evaluate node at pointer, store in result register 8+pointer, increment pointer; after node cfg_len-1 go FIN.
REQ-021 FIN: done=1, out=last node result, err=0, return IDLE.
REQ-022 Latency: start accepted in cycle t -> done in cycle t+cfg_len+1.
REQ-023 Forward/self reference (node k operand idx >= 8+k, or idx >= 8+cfg_len): abort in that cycle, go FIN with err=1, out=0.
REQ-024 cfg_len=0 or >8 at start: go FIN directly (done at t+1), err=1, out=0.
REQ-025 cfg_we honoured only in IDLE (including cycle start is sampled; write lands before next run); ignored while busy.
REQ-026 x changes after start do not affect the running evaluation.
REQ-027 start on the same cycle as done (FIN) is ignored; new start accepted from IDLE next cycle.
REQ-028 Program memory contents persist across runs and are not cleared by done.

Reset
REQ-029 rst=1 forces IDLE, busy=0, done=0, out=0, err=0, pointer=0, node results=0, asynchronously.
REQ-030 Program memory contents after reset are all-zero (each node = MAJ(x0,x0,x0)).
REQ-031 Reset mid-EVAL aborts run with no done pulse; first start after release behaves as from power-up.

Verification
REQ-032 Program n0=MAJ(x3,x5,x6), n1=MAJ(x2,x4,n0), n2=MAJ(x0,x2,x5), n3=MAJ(x3,n1,n2), n4=MAJ(x0,x1,n3), len=5; x=7'b1111111 -> done 6 cycles after start, out=1, err=0; x=0 -> out=0.
REQ-033 Same program, x0=1,x1=0,x2=0,x3=1,x4=0,x5=1,x6=0 (x=7'b0101001) -> out=1; change x during EVAL -> out unchanged.
REQ-034 n0=MAJ(~idx7,x0,x1), len=1: x=7'b0000000 -> out=0; x=7'b0000010 -> out=1; done 2 cycles after start.
REQ-035 n0 operand A idx=8 (self), len=1 -> done with err=1, out=0; cfg_len=0 -> done at t+1, err=1.
REQ-036 Assert rst during EVAL of 5-node run -> busy=0, out=0 immediately, no done; restart -> correct result; cfg_we while busy -> program unchanged.
